uart_tx_dev: RTL and testbench
==============================

# uart_tx_dev

Memory-mapped UART transmitter that sits as a device-side responder on the bridge's device bus, next to the counter, screen board and seven-segment devices. It accepts bytes from CPU stores into an 8-entry FIFO and serialises them as 8N1 frames on `tx`. It raises a level interrupt on the bridge's `HWInt` vector when the transmitter has drained and the interrupt is enabled.

## Interface
- `CLK_DIV`, 868: clock cycles per bit period (100 MHz / 115200); legal range 2..65535.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of two, 2..16.
- `clk` in 1: sole clock; all state updates on rising edge.
- `rst_n` in 1: reset is asynchronous, active-low.
- `D` in 32: write data from bridge (`DEV_WD`).
- `A` in 1: word offset within the device. 0 = TXDATA, 1 = CTRL/STATUS.
- `be` in 4: byte enables; only `be[0]` is significant.
- `we` in 1: write strobe, already decoded by the bridge for this device.
- `Dout` out 32: read data, combinational from `A`.
- `INT` out 1: level interrupt to `HWInt`.
- `tx` out 1: serial output; idles high.

## Operation
- Writes are accepted when `we && be[0]`. Writes without `be[0]` are ignored.
- A TXDATA write pushes `D[7:0]` into the FIFO. Reads of TXDATA return 0.
- CTRL/STATUS layout:
  - bit0 `busy`: FSM is not in IDLE (RO).
  - bit1 `full`: FIFO holds `FIFO_DEPTH` entries (RO).
  - bit2 `empty`: FIFO holds no entries (RO).
  - bit3 `ie`: interrupt enable (RW).
  - bit4 `ovf`: sticky overflow flag; write-1-to-clear.
  - bits[12:8]: FIFO count (RO).
  - All other bits read 0.
- A CTRL write updates `ie` from `D[3]` and clears `ovf` if `D[4]` is 1. Other bits are ignored.
- Push to a full FIFO:
  - The byte is dropped and `ovf` sets.
  - Exception: if the FSM pops in the same cycle, the push is accepted and the count is unchanged.
- Overflow set and W1C on the same cycle: set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: if the FIFO is not empty, pop into the shift register and go to START.
  - START: `tx`=0 for `CLK_DIV` cycles, then go to DATA with bit index 0.
  - DATA: `tx` = `shift[0]` (LSB first) for `CLK_DIV` cycles per bit, shift right, increment index. After bit 7 completes, go to STOP.
  - STOP: `tx`=1 for `CLK_DIV` cycles, then return to IDLE.
- Baud counter: counts 0..`CLK_DIV`-1 and resets to 0 on every state entry. Width is $clog2(`CLK_DIV`). Bit index is 3 bits.
- `INT` = `ie && empty && !busy`. It is registered, so it asserts one cycle after the condition holds.

## Timing
- Reset values:
  - `tx`=1, `INT`=0, `Dout` reflects reset state (STATUS reads 0x4 at A=1).
  - FIFO empty, `ie`=0, `ovf`=0, FSM IDLE, counters 0.
- Write latency: a push at edge N is visible in STATUS count after edge N.
  - If the FSM was idle, it pops at edge N+1.
  - `tx` falls after edge N+2.
- Frame length is exactly 10·`CLK_DIV` cycles.
- One IDLE cycle separates back-to-back frames, so the frame period is 10·`CLK_DIV`+1.
- `busy` is high from the cycle after the pop until the cycle after the last STOP cycle.
- Asynchronous reset mid-frame: `tx` returns high immediately and FIFO contents are lost. No partial frame resumes.

## Structure
- Package `uart_tx_pkg`:
  - register offsets `TXDATA_OFF`=0, `CTRL_OFF`=1;
  - status bit-position localparams;
  - enum `uart_tx_state_t` {IDLE, START, DATA, STOP}.
- Sub-module `uart_tx_fifo`: synchronous FIFO with push/pop/full/empty/count, parameterised by depth and width 8, async active-low reset.
- Top level holds register decode, FSM, baud counter and shifter.

## Test plan
- Reset, then read A=1 → `Dout`=0x00000004, `tx`=1, `INT`=0.
- `CLK_DIV`=4: write 0xA5 to TXDATA → `tx` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles. The start bit begins 2 cycles after the write edge.
- `CLK_DIV`=4: write 9 bytes on consecutive cycles while IDLE.
  - The first byte pops, 8 remain, all accepted, count=8, `full`=1, `ovf`=0.
  - A 10th write → dropped, `ovf`=1.
  - Writing CTRL with 0x10 → `ovf`=0.
- Write `ie`=1 (CTRL=0x8) with FIFO empty → `INT`=1 one cycle later. Write a byte → `INT` drops, then reasserts one cycle after the STOP bit ends.
- Two bytes 0x00, 0xFF back-to-back → frames separated by exactly 1 idle cycle. Total 2·10·`CLK_DIV`+1 cycles from the first start-bit edge to the end of the last stop bit.
- Assert `rst_n`=0 during DATA bit 3 → `tx`=1 asynchronously, count=0. After release, no residual frame is transmitted.

Source files
------------

// File: rtl/uart_tx_pkg.sv
// Shared register map, status bit positions and FSM state encoding for the
// memory-mapped UART transmitter.
package uart_tx_pkg;

    localparam logic TXDATA_OFF = 1'b0;
    localparam logic CTRL_OFF   = 1'b1;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_IE      = 3;
    localparam int ST_OVF     = 4;
    localparam int ST_CNT_LSB = 8;
    localparam int ST_CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_tx_state_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO feeding the transmitter; head entry is readable
// combinationally so the FSM can load its shifter on the pop edge.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = mem_q[rd_ptr_q];

    // A push into a full FIFO still lands when the same cycle frees a slot.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
        if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Bridge-attached 8N1 UART transmitter: register decode, TX FIFO, frame FSM
// with baud counter and shifter, and a registered drain interrupt.
module uart_tx_dev
    import uart_tx_pkg::*;
#(
    parameter int CLK_DIV    = 868,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] D,
    input  logic        A,
    input  logic [3:0]  be,
    input  logic        we,
    output logic [31:0] Dout,
    output logic        INT,
    output logic        tx
);

    localparam int BW  = $clog2(CLK_DIV);
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BW-1:0] BAUD_MAX = BW'(CLK_DIV - 1);

    uart_tx_state_t state_q, state_d;
    logic [BW-1:0]  baud_q, baud_d;
    logic [2:0]     idx_q, idx_d;
    logic [7:0]     shift_q, shift_d;
    logic           tx_q, tx_d;
    logic           ie_q, ie_d;
    logic           ovf_q, ovf_d;
    logic           int_q, int_d;

    logic           wr_en, txdata_wr, ctrl_wr, push_drop, busy, baud_done;
    logic           fifo_pop, fifo_full, fifo_empty;
    logic [7:0]     fifo_rdata;
    logic [FCW-1:0] fifo_count;
    logic           unused_bits;

    assign unused_bits = ^{D[31:8], be[3:1]};

    assign wr_en     = we && be[0];
    assign txdata_wr = wr_en && (A == TXDATA_OFF);
    assign ctrl_wr   = wr_en && (A == CTRL_OFF);
    assign push_drop = txdata_wr && fifo_full && !fifo_pop;
    assign busy      = (state_q != IDLE);
    assign baud_done = (baud_q == BAUD_MAX);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (txdata_wr),
        .pop   (fifo_pop),
        .wdata (D[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        idx_d    = idx_q;
        shift_d  = shift_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_rdata;
                    baud_d   = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (baud_done) begin
                    baud_d  = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) state_d = STOP;
                    else               idx_d   = idx_q + 3'd1;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + BW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx is registered from the current state, so the line lags the FSM by one cycle.
    always_comb begin
        tx_d = 1'b1;
        case (state_q)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_q[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        ie_d  = ctrl_wr ? D[ST_IE] : ie_q;
        ovf_d = ovf_q;
        if (push_drop)                ovf_d = 1'b1;
        else if (ctrl_wr && D[ST_OVF]) ovf_d = 1'b0;
        int_d = ie_q && fifo_empty && !busy;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ie_q    <= 1'b0;
            ovf_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ie_q    <= ie_d;
            ovf_q   <= ovf_d;
            int_q   <= int_d;
        end
    end

    always_comb begin
        Dout = '0;
        if (A == CTRL_OFF) begin
            Dout[ST_BUSY]                   = busy;
            Dout[ST_FULL]                   = fifo_full;
            Dout[ST_EMPTY]                  = fifo_empty;
            Dout[ST_IE]                     = ie_q;
            Dout[ST_OVF]                    = ovf_q;
            Dout[ST_CNT_LSB +: ST_CNT_W]    = ST_CNT_W'(fifo_count);
        end
    end

    assign tx  = tx_q;
    assign INT = int_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed bench for uart_tx_dev with a byte scoreboard drained by a serial
// frame monitor on tx.
module tb_uart_tx_dev;

    localparam int DIV = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] D;
    logic        A;
    logic [3:0]  be;
    logic        we;
    logic [31:0] Dout;
    logic        INT;
    logic        tx;

    int tests = 0;
    int fails = 0;
    logic [7:0] sb[$];

    uart_tx_dev #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .D     (D),
        .A     (A),
        .be    (be),
        .we    (we),
        .Dout  (Dout),
        .INT   (INT),
        .tx    (tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic a, input logic [31:0] d, input logic [3:0] b);
        @(negedge clk);
        A = a; D = d; be = b; we = 1'b1;
        @(negedge clk);
        we = 1'b0; be = 4'h0; A = 1'b1;
        #1;
    endtask

    // Writes n bytes to TXDATA on consecutive edges and records each as expected.
    task automatic burst(input logic [7:0] b0, input int n, input logic [7:0] step);
        logic [7:0] b;
        b = b0;
        @(negedge clk);
        A = 1'b0; be = 4'h1; we = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i != 0) @(negedge clk);
            D = {24'h0, b};
            sb.push_back(b);
            b = b + step;
        end
        @(negedge clk);
        we = 1'b0; be = 4'h0; A = 1'b1;
        #1;
    endtask

    // Frame monitor: decodes 8N1 frames on tx and retires scoreboard entries.
    initial begin : monitor
        logic       prev;
        logic       ab;
        logic [9:0] fr;
        logic [7:0] exp;
        prev = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n && prev && !tx) begin
                fr = '0;
                fr[0] = tx;
                ab = 1'b0;
                for (int k = 1; k < 10; k++) begin
                    repeat (DIV) @(negedge clk);
                    if (!rst_n) begin
                        ab = 1'b1;
                        break;
                    end
                    fr[k] = tx;
                end
                if (!ab) begin
                    chk("frame_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        exp = sb.pop_front();
                        chk("frame_data", 32'(fr[8:1]), 32'(exp));
                        chk("frame_stop", 32'(fr[9]), 32'd1);
                    end
                end
            end
            prev = tx;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [9:0] pat_a5;
        logic       s   [82];
        logic [31:0] st [82];
        bit         found;
        int         gap, ones, lows;

        pat_a5 = 10'b1101001010;
        rst_n = 1'b0; we = 1'b0; A = 1'b1; D = '0; be = 4'h0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_status", Dout, 32'h4);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_int", 32'(INT), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_status", Dout, 32'h4);
        chk("post_rst_tx", 32'(tx), 32'd1);

        // Single frame 0xA5 with exact bit timing
        sb.push_back(8'hA5);
        write(1'b0, 32'h000000A5, 4'h1);
        chk("a5_count1", Dout, 32'h00000100);
        chk("a5_tx_w0", 32'(tx), 32'd1);
        @(negedge clk);
        chk("a5_busy", Dout, 32'h5);
        chk("a5_tx_w1", 32'(tx), 32'd1);
        for (int k = 0; k < 10; k++) begin
            for (int c = 0; c < DIV; c++) begin
                @(negedge clk);
                chk($sformatf("a5_bit%0d_c%0d", k, c), 32'(tx), 32'(pat_a5[k]));
            end
        end
        chk("a5_idle", Dout, 32'h4);

        // Fill FIFO, overflow, W1C, ignored byte-enable, TXDATA readback
        burst(8'h10, 9, 8'h01);
        chk("ovf_full", Dout, 32'h00000803);
        write(1'b0, 32'h000000EE, 4'h1);
        chk("ovf_set", Dout, 32'h00000813);
        write(1'b1, 32'h00000010, 4'h1);
        chk("ovf_clear", Dout, 32'h00000803);
        write(1'b1, 32'h00000018, 4'hE);
        chk("be0_ignored", Dout, 32'h00000803);
        A = 1'b0;
        #1;
        chk("txdata_read0", Dout, 32'h0);
        A = 1'b1;
        #1;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            if (Dout === 32'h4) found = 1'b1;
        end
        chk("drain_idle", Dout, 32'h4);
        repeat (3) @(negedge clk);

        // Interrupt enable, drop on push, reassert after drain
        write(1'b1, 32'h00000008, 4'h1);
        chk("ie_int_lag", 32'(INT), 32'd0);
        chk("ie_status", Dout, 32'hC);
        @(negedge clk);
        chk("ie_int_on", 32'(INT), 32'd1);
        sb.push_back(8'h3C);
        write(1'b0, 32'h0000003C, 4'h1);
        chk("int_hold_push", 32'(INT), 32'd1);
        @(negedge clk);
        chk("int_drop", 32'(INT), 32'd0);
        repeat (40) @(negedge clk);
        chk("int_low_end", 32'(INT), 32'd0);
        @(negedge clk);
        chk("int_reassert", 32'(INT), 32'd1);
        write(1'b1, 32'h00000000, 4'h1);

        // Back-to-back 0x00, 0xFF
        burst(8'h00, 2, 8'hFF);
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            if (tx === 1'b0) found = 1'b1;
        end
        chk("b2b_start_seen", 32'(found), 32'd1);
        s[0] = tx;
        st[0] = Dout;
        for (int j = 1; j < 82; j++) begin
            @(negedge clk);
            s[j] = tx;
            st[j] = Dout;
        end
        gap = 0;
        for (int j = 1; j < 82; j++)
            if (gap == 0 && s[j-1] === 1'b1 && s[j] === 1'b0) gap = j;
        chk("b2b_period", 32'(gap), 32'(10 * DIV + 1));
        ones = 0;
        for (int j = 0; j < 41; j++)
            if (s[j] === 1'b1) ones++;
        chk("b2b_high_run", 32'(ones), 32'(DIV + 1));
        chk("b2b_busy_last", 32'(st[79][0]), 32'd1);
        chk("b2b_idle_end", st[80], 32'h4);
        chk("b2b_tx_end", 32'(s[80]), 32'd1);

        // Asynchronous reset in the middle of data bit 3
        burst(8'h5A, 2, 8'h0C);
        repeat (18) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tx", 32'(tx), 32'd1);
        chk("arst_status", Dout, 32'h4);
        chk("arst_int", 32'(INT), 32'd0);
        sb.delete();
        repeat (6) @(negedge clk);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        chk("no_residual_frame", 32'(lows), 32'd0);
        chk("post_arst_status", Dout, 32'h4);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
